// File: rtl/fifo_pkg.sv
// Shared definitions for the syn_fifo_flex FIFO slice: read-mode selector and a
// ceil(log2) helper for callers that size fields from a depth.
package fifo_pkg;

    typedef enum logic {
        FIFO_MODE_STD  = 1'b0,
        FIFO_MODE_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/syn_fifo_flex_if.sv
// Producer/consumer bundle for syn_fifo_flex. The FIFO side uses the slave
// modport; whoever writes and reads the FIFO uses the master modport.
interface syn_fifo_flex_if #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 9
);

    // A write is taken on a rising edge with winc=1 and wfull=0, a read on an
    // edge with rinc=1 and rempty=0; both flags are the values held before that
    // edge, so winc/rinc act as valid and ~wfull/~rempty as ready.
    logic [DSIZE-1:0] wdata;
    logic             winc;
    logic             wfull;
    logic             walmost_full;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             ralmost_empty;
    logic [ASIZE:0]   count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wdata, winc, rinc,
        input  wfull, walmost_full, rdata, rempty, ralmost_empty, count,
               overflow, underflow
    );

    modport slave (
        input  wdata, winc, rinc,
        output wfull, walmost_full, rdata, rempty, ralmost_empty, count,
               overflow, underflow
    );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, registered synchronous read,
// no reset on the array. RAM_TYPE selects the ram_style hint.
module fifo_ram #(
    parameter int    DSIZE    = 32,
    parameter int    ASIZE    = 9,
    parameter string RAM_TYPE = "block"
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic             re,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    localparam int DEPTH = 2 ** ASIZE;

    // Each branch carries a literal attribute so every synthesis tool sees it.
    if (RAM_TYPE == "distributed") begin : g_dist
        (* ram_style = "distributed" *) logic [DSIZE-1:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (we) mem[waddr] <= wdata;
            if (re) rdata <= mem[raddr];
        end
    end else if (RAM_TYPE == "block") begin : g_block
        (* ram_style = "block" *) logic [DSIZE-1:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (we) mem[waddr] <= wdata;
            if (re) rdata <= mem[raddr];
        end
    end else begin : g_auto
        (* ram_style = "auto" *) logic [DSIZE-1:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (we) mem[waddr] <= wdata;
            if (re) rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/syn_fifo_flex.sv
// Single-clock FIFO with registered flags, selectable standard or
// first-word-fall-through read, and overflow/underflow pulses.
module syn_fifo_flex
    import fifo_pkg::*;
#(
    parameter int         DSIZE      = 32,
    parameter int         ASIZE      = 9,
    parameter string      RAM_TYPE   = "block",
    parameter fifo_mode_e MODE       = FIFO_MODE_STD,
    parameter int         AFULL_LVL  = (2 ** ASIZE) - 4,
    parameter int         AEMPTY_LVL = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    syn_fifo_flex_if.slave bus
);

    localparam int             PW         = ASIZE + 1;
    localparam logic [ASIZE:0] AFULL_C    = PW'(AFULL_LVL);
    localparam logic [ASIZE:0] AEMPTY_C   = PW'(AEMPTY_LVL);
    localparam logic [ASIZE:0] FULL_XOR   = {1'b1, {ASIZE{1'b0}}};
    localparam bit             FWFT       = (MODE == FIFO_MODE_FWFT);

    // wptr: next slot to write; hptr: head word as seen by the reader;
    // fptr: next RAM word to prefetch into the output register (FWFT only).
    logic [ASIZE:0]   wptr;
    logic [ASIZE:0]   hptr;
    logic [ASIZE:0]   fptr;
    logic             head_valid;
    logic             rd_seen;
    logic [ASIZE:0]   count_q;
    logic             wfull_q;
    logic             rempty_q;
    logic             walmost_full_q;
    logic             ralmost_empty_q;
    logic             overflow_q;
    logic             underflow_q;

    logic             wr_acc;
    logic             rd_acc;
    logic             mem_nonempty;
    logic             fetch;
    logic             head_valid_n;
    logic             ram_re;
    logic [ASIZE-1:0] ram_raddr;
    logic [ASIZE:0]   wptr_n;
    logic [ASIZE:0]   hptr_n;
    logic [ASIZE:0]   fptr_n;
    logic [ASIZE:0]   count_n;
    logic [DSIZE-1:0] ram_q;

    always_comb begin
        wr_acc       = bus.winc & ~wfull_q;
        rd_acc       = bus.rinc & ~rempty_q;
        mem_nonempty = (fptr != wptr);
        // Refill the output register whenever it is empty or being popped.
        fetch        = FWFT && mem_nonempty && (!head_valid || rd_acc);
        head_valid_n = fetch | (head_valid & ~rd_acc);
        wptr_n       = wptr + PW'(wr_acc);
        hptr_n       = hptr + PW'(rd_acc);
        fptr_n       = fptr + PW'(fetch);
        count_n      = wptr_n - hptr_n;
        ram_re       = FWFT ? fetch : rd_acc;
        ram_raddr    = FWFT ? fptr[ASIZE-1:0] : hptr[ASIZE-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr            <= '0;
            hptr            <= '0;
            fptr            <= '0;
            head_valid      <= 1'b0;
            rd_seen         <= 1'b0;
            count_q         <= '0;
            wfull_q         <= 1'b0;
            rempty_q        <= 1'b1;
            walmost_full_q  <= 1'b0;
            ralmost_empty_q <= 1'b1;
            overflow_q      <= 1'b0;
            underflow_q     <= 1'b0;
        end else begin
            wptr            <= wptr_n;
            hptr            <= hptr_n;
            fptr            <= fptr_n;
            head_valid      <= head_valid_n;
            count_q         <= count_n;
            // Same low bits, different wrap bit: DEPTH words outstanding.
            wfull_q         <= ((wptr_n ^ hptr_n) == FULL_XOR);
            rempty_q        <= FWFT ? ~head_valid_n : (wptr_n == hptr_n);
            walmost_full_q  <= (count_n >= AFULL_C);
            ralmost_empty_q <= (count_n <= AEMPTY_C);
            overflow_q      <= bus.winc & wfull_q;
            underflow_q     <= bus.rinc & rempty_q;
            if (ram_re) rd_seen <= 1'b1;
        end
    end

    fifo_ram #(
        .DSIZE    (DSIZE),
        .ASIZE    (ASIZE),
        .RAM_TYPE (RAM_TYPE)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr[ASIZE-1:0]),
        .wdata (bus.wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

    // The RAM output register has no reset, so it is masked until the first read.
    assign bus.rdata         = rd_seen ? ram_q : '0;
    assign bus.count         = count_q;
    assign bus.wfull         = wfull_q;
    assign bus.rempty        = rempty_q;
    assign bus.walmost_full  = walmost_full_q;
    assign bus.ralmost_empty = ralmost_empty_q;
    assign bus.overflow      = overflow_q;
    assign bus.underflow     = underflow_q;

endmodule

// File: tb/tb_syn_fifo_flex.sv
// Directed bench for syn_fifo_flex: one standard-mode and one FWFT instance,
// DEPTH=4, AFULL_LVL=3, AEMPTY_LVL=1, 8-bit data.
module tb_syn_fifo_flex;
    import fifo_pkg::*;

    localparam int DSIZE = 8;
    localparam int ASIZE = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [DSIZE-1:0] exp_q[$];
    logic [DSIZE-1:0] exp_v;
    logic [DSIZE-1:0] fill_v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    always #5 clk = ~clk;

    syn_fifo_flex_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) s_if ();
    syn_fifo_flex_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) f_if ();

    syn_fifo_flex #(
        .DSIZE(DSIZE), .ASIZE(ASIZE), .RAM_TYPE("block"),
        .MODE(FIFO_MODE_STD), .AFULL_LVL(3), .AEMPTY_LVL(1)
    ) u_std (
        .clk(clk), .rst_n(rst_n), .bus(s_if)
    );

    syn_fifo_flex #(
        .DSIZE(DSIZE), .ASIZE(ASIZE), .RAM_TYPE("distributed"),
        .MODE(FIFO_MODE_FWFT), .AFULL_LVL(3), .AEMPTY_LVL(1)
    ) u_fwft (
        .clk(clk), .rst_n(rst_n), .bus(f_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        s_if.winc = 1'b0; s_if.rinc = 1'b0; s_if.wdata = '0;
        f_if.winc = 1'b0; f_if.rinc = 1'b0; f_if.wdata = '0;
        rst_n = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_count", s_if.count, 0);
        check("rst_rempty", s_if.rempty, 1);
        check("rst_wfull", s_if.wfull, 0);
        check("rst_walmost_full", s_if.walmost_full, 0);
        check("rst_ralmost_empty", s_if.ralmost_empty, 1);
        check("rst_rdata", s_if.rdata, 0);
        check("rst_overflow", s_if.overflow, 0);
        check("rst_underflow", s_if.underflow, 0);
        check("rst_f_rempty", f_if.rempty, 1);
        check("rst_f_rdata", f_if.rdata, 0);

        // STD fill: first write lands on the first edge with rst_n=1
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_if.winc = 1'b1;
            s_if.wdata = fill_v[i];
            exp_q.push_back(fill_v[i]);
            tick();
            check("std_fill_count", s_if.count, i + 1);
            check("std_fill_rempty", s_if.rempty, 0);
            check("std_fill_wfull", s_if.wfull, (i == 3));
            check("std_fill_afull", s_if.walmost_full, (i + 1 >= 3));
            check("std_fill_aempty", s_if.ralmost_empty, (i + 1 <= 1));
        end

        // Overflow while full
        s_if.wdata = 8'h55;
        tick();
        s_if.winc = 1'b0;
        check("std_ovf_pulse", s_if.overflow, 1);
        check("std_ovf_count", s_if.count, 4);
        tick();
        check("std_ovf_clear", s_if.overflow, 0);
        check("std_ovf_hold", s_if.count, 4);

        // Full with simultaneous winc and rinc: read taken, write refused
        s_if.winc = 1'b1; s_if.wdata = 8'h66; s_if.rinc = 1'b1;
        tick();
        s_if.winc = 1'b0;
        exp_v = exp_q.pop_front();
        check("std_fullrw_rdata", s_if.rdata, exp_v);
        check("std_fullrw_count", s_if.count, 3);
        check("std_fullrw_wfull", s_if.wfull, 0);
        check("std_fullrw_ovf", s_if.overflow, 1);

        for (int i = 0; i < 3; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            check("std_drain_rdata", s_if.rdata, exp_v);
            check("std_drain_count", s_if.count, 2 - i);
        end
        s_if.rinc = 1'b0;
        check("std_drain_rempty", s_if.rempty, 1);
        check("std_drain_afull", s_if.walmost_full, 0);
        check("std_drain_aempty", s_if.ralmost_empty, 1);

        // Underflow; rdata holds the last word
        s_if.rinc = 1'b1;
        tick();
        s_if.rinc = 1'b0;
        check("std_udf_pulse", s_if.underflow, 1);
        check("std_udf_rdata_hold", s_if.rdata, 8'h44);
        check("std_udf_count", s_if.count, 0);
        tick();
        check("std_udf_clear", s_if.underflow, 0);

        // Wrap: 10 cycles of read+write at count=2
        s_if.winc = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_if.wdata = 8'hA0 + 8'(i);
            exp_q.push_back(s_if.wdata);
            tick();
        end
        check("std_wrap_start_count", s_if.count, 2);
        s_if.rinc = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_if.wdata = 8'hB0 + 8'(i);
            exp_q.push_back(s_if.wdata);
            tick();
            exp_v = exp_q.pop_front();
            check("std_wrap_rdata", s_if.rdata, exp_v);
            check("std_wrap_count", s_if.count, 2);
            check("std_wrap_aempty", s_if.ralmost_empty, 0);
            check("std_wrap_afull", s_if.walmost_full, 0);
        end
        s_if.winc = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            check("std_wrap_drain", s_if.rdata, exp_v);
        end
        s_if.rinc = 1'b0;
        check("std_wrap_empty", s_if.rempty, 1);

        // Reset mid-operation with count=3; winc/rinc ignored that edge
        s_if.winc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_if.wdata = 8'hC1 + 8'(i);
            tick();
        end
        check("std_prerst_count", s_if.count, 3);
        rst_n = 1'b0; s_if.wdata = 8'h77; s_if.rinc = 1'b1;
        tick();
        check("std_midrst_count", s_if.count, 0);
        check("std_midrst_rempty", s_if.rempty, 1);
        check("std_midrst_rdata", s_if.rdata, 0);
        check("std_midrst_wfull", s_if.wfull, 0);
        rst_n = 1'b1; s_if.winc = 1'b0;
        tick();
        s_if.rinc = 1'b0;
        check("std_postrst_udf", s_if.underflow, 1);
        check("std_postrst_count", s_if.count, 0);
        exp_q.delete();

        // FWFT: single write into empty shows up two edges later
        f_if.winc = 1'b1; f_if.wdata = 8'hA5;
        tick();
        f_if.winc = 1'b0;
        check("fwft_e1_rempty", f_if.rempty, 1);
        check("fwft_e1_count", f_if.count, 1);
        tick();
        check("fwft_e2_rempty", f_if.rempty, 0);
        check("fwft_e2_rdata", f_if.rdata, 8'hA5);
        f_if.rinc = 1'b1;
        tick();
        f_if.rinc = 1'b0;
        check("fwft_pop_rempty", f_if.rempty, 1);
        check("fwft_pop_count", f_if.count, 0);
        f_if.rinc = 1'b1;
        tick();
        f_if.rinc = 1'b0;
        check("fwft_udf_pulse", f_if.underflow, 1);

        // FWFT: fill to full, then back-to-back pops
        f_if.winc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            f_if.wdata = 8'hC0 + 8'(i);
            exp_q.push_back(f_if.wdata);
            tick();
        end
        f_if.winc = 1'b0;
        check("fwft_full_count", f_if.count, 4);
        check("fwft_full_wfull", f_if.wfull, 1);
        check("fwft_full_head", f_if.rdata, 8'hC0);
        f_if.rinc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            check("fwft_b2b_count", f_if.count, 3 - i);
            if (exp_q.size() > 0) begin
                check("fwft_b2b_rempty", f_if.rempty, 0);
                check("fwft_b2b_rdata", f_if.rdata, exp_q[0]);
            end else begin
                check("fwft_b2b_last_rempty", f_if.rempty, 1);
            end
        end
        f_if.rinc = 1'b0;

        // FWFT wrap at count=2
        f_if.winc = 1'b1;
        for (int i = 0; i < 2; i++) begin
            f_if.wdata = 8'hD0 + 8'(i);
            exp_q.push_back(f_if.wdata);
            tick();
        end
        check("fwft_wrap_head", f_if.rdata, 8'hD0);
        f_if.rinc = 1'b1;
        for (int i = 0; i < 10; i++) begin
            f_if.wdata = 8'hE0 + 8'(i);
            exp_q.push_back(f_if.wdata);
            tick();
            exp_v = exp_q.pop_front();
            check("fwft_wrap_rdata", f_if.rdata, exp_q[0]);
            check("fwft_wrap_rempty", f_if.rempty, 0);
            check("fwft_wrap_count", f_if.count, 2);
            check("fwft_wrap_aempty", f_if.ralmost_empty, 0);
            check("fwft_wrap_afull", f_if.walmost_full, 0);
        end
        f_if.winc = 1'b0;
        f_if.rinc = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
